room_thermal_model: RTL
=======================

Name: room_thermal_model

Overview:
Behavioural-synthesizable plant model of the room that the temperature controller regulates. It consumes the controller's heat/cool commands (h, c) and produces the room temperature (troom) fed back to the controller, closing the loop for system-level simulation and FPGA demos. Temperature moves at fixed per-mode rates, with saturation at the representable range and drift toward ambient when idle.

Parameters:
TEMP_W, 7, width of all temperature buses (unsigned degrees)
HEAT_PERIOD, 4, cycles in HEAT per +1 degree (>=1)
COOL_PERIOD, 4, cycles in COOL per -1 degree (>=1)
DRIFT_PERIOD, 16, cycles in DRIFT per 1-degree step toward tamb (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  model enable; 0 freezes temperature
load  in  1  1-cycle pulse: troom <= tinit
tinit  in  TEMP_W  initial room temperature for load
tamb  in  TEMP_W  ambient temperature, drift target
h  in  1  heater on (from controller)
c  in  1  cooler on (from controller)
troom  out  TEMP_W  modelled room temperature (registered)
mode  out  2  current mode: 0 IDLE, 1 HEAT, 2 COOL, 3 DRIFT
sat  out  1  1-cycle pulse: a step was blocked by range limit
err  out  1  sticky: h and c seen high together while start=1

Behaviour:
- One clock; reset is synchronous and active-low. reset=0 at an edge: troom=0, mode=IDLE, cycle counter=0, sat=0, err=0; overrides load and everything else, including mid-step.
- Priority per edge (reset high): load > mode update/stepping. load=1: troom<=tinit, counter<=0, mode unchanged, no step that cycle.
- next_mode (combinational): start=0 -> IDLE; start=1,h=1,c=0 -> HEAT; h=0,c=1 -> COOL; h=0,c=0 -> DRIFT; h=1,c=1 -> DRIFT and err<=1 (sticky until reset).
- If next_mode != mode: mode<=next_mode, counter<=0, no step.
- Else counter increments; when counter == PERIOD(mode)-1: counter<=0 and step applied:
  HEAT: troom+1, saturate at 2^TEMP_W-1; COOL: troom-1, saturate at 0; DRIFT: troom moves 1 toward tamb, no change if equal (not a saturation); IDLE: counter held at 0, troom held.
- Saturation: HEAT at max or COOL at 0 -> troom unchanged, sat=1 for that cycle, counter still wraps to 0.
- Latency: h held high from first sampled edge E0 with start=1 and mode!=HEAT: mode=HEAT after E0, first increment at edge E0+HEAT_PERIOD, then every HEAT_PERIOD edges.
- Mode change mid-period discards partial progress (counter restarts).
- tamb may change at any time; DRIFT direction re-evaluated at each step.
- All arithmetic unsigned TEMP_W bits, no wrap-around ever on troom.

Decomposition:
- Package temp_pkg: TEMP_W default, mode_t enum (IDLE, HEAT, COOL, DRIFT) with fixed 2-bit encoding above; shared with the controller and its bench.
- Sub-module period_tick: counter with clear, enable, runtime period input; outputs tick when count==period-1, wraps to 0. Instantiated once; period muxed by mode.

Test Plan:
- Reset: drive h=1,start=1, reset=0 for 2 edges -> troom=0, mode=0, err=0, sat=0.
- Heat rate: load tinit=50, start=1,h=1,c=0 -> mode=1 after 1 edge, troom=51 at 4th edge after h sampled, 52 at 8th, 55 at 20th.
- Cool + saturation: load tinit=1, c=1 -> troom=0 after 4 edges post-mode change; next 4 edges -> troom stays 0, sat pulses 1 cycle.
- Drift: tinit=60, tamb=58, h=c=0, start=1 -> 59 at 16 edges, 58 at 32, stays 58 thereafter, sat never asserts.
- Mode switch mid-period: heat 2 cycles then c=1 -> no step, counter restarts, first decrement 4 edges after mode=2; h=c=1 -> mode=3, err=1 and stays 1 after h,c drop.
- Closed loop: connect to controller, tref=60, dt=1, tinit=50 -> troom rises to 59..61 band and oscillates inside it; start=0 freezes troom, mode=0.

Source files
------------

// File: rtl/temp_pkg.sv
// Shared types and defaults for the room thermal plant and its controller.
package temp_pkg;

  localparam int TEMP_W_DEFAULT = 7;
  localparam int CNT_W          = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HEAT  = 2'd1,
    COOL  = 2'd2,
    DRIFT = 2'd3
  } mode_t;

  // Mode requested by the current inputs; h and c together fall back to drift.
  function automatic mode_t next_mode_f(input logic start, input logic h, input logic c);
    if (!start)
      return IDLE;
    else if (h && !c)
      return HEAT;
    else if (!h && c)
      return COOL;
    else
      return DRIFT;
  endfunction

endpackage

// File: rtl/room_thermal_model_period_tick.sv
// Free-running period counter: tick on the last count of each period.
module period_tick
  import temp_pkg::*;
#(
  parameter int CNT_W_P = CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               en,
  input  logic [CNT_W_P-1:0] period,
  output logic               tick
);

  logic [CNT_W_P-1:0] count;

  assign tick = en && (count == period - CNT_W_P'(1));

  // Count while enabled, wrap on tick, restart on clear.
  always_ff @(posedge clk) begin
    if (!reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (en) begin
      if (tick)
        count <= '0;
      else
        count <= count + CNT_W_P'(1);
    end
  end

endmodule

// File: rtl/room_thermal_model.sv
// Room temperature plant: steps troom at per-mode rates from heat/cool commands.
module room_thermal_model
  import temp_pkg::*;
#(
  parameter int TEMP_W       = TEMP_W_DEFAULT,
  parameter int HEAT_PERIOD  = 4,
  parameter int COOL_PERIOD  = 4,
  parameter int DRIFT_PERIOD = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load,
  input  logic [TEMP_W-1:0] tinit,
  input  logic [TEMP_W-1:0] tamb,
  input  logic              h,
  input  logic              c,
  output logic [TEMP_W-1:0] troom,
  output logic [1:0]        mode,
  output logic              sat,
  output logic              err
);

  mode_t            mode_q;
  mode_t            next_mode;
  logic             mode_chg;
  logic             clear;
  logic             tick;
  logic [CNT_W-1:0] period;

  assign next_mode = next_mode_f(start, h, c);
  assign mode_chg  = (next_mode != mode_q);
  // A load, a mode change or idling all discard partial progress of the period.
  assign clear     = load || mode_chg || (mode_q == IDLE);
  assign mode      = mode_q;

  // Period select for the current mode; IDLE never ticks, its value is unused.
  always_comb begin
    period = CNT_W'(DRIFT_PERIOD);
    case (mode_q)
      HEAT:    period = CNT_W'(HEAT_PERIOD);
      COOL:    period = CNT_W'(COOL_PERIOD);
      default: period = CNT_W'(DRIFT_PERIOD);
    endcase
  end

  period_tick #(
    .CNT_W_P (CNT_W)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .en     (!clear),
    .period (period),
    .tick   (tick)
  );

  // Mode, temperature stepping with saturation, and sticky error flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      troom  <= '0;
      mode_q <= IDLE;
      sat    <= 1'b0;
      err    <= 1'b0;
    end else begin
      sat <= 1'b0;
      if (start && h && c)
        err <= 1'b1;
      if (load) begin
        troom <= tinit;
      end else if (mode_chg) begin
        mode_q <= next_mode;
      end else if (tick) begin
        case (mode_q)
          HEAT: begin
            if (troom == '1)
              sat <= 1'b1;
            else
              troom <= troom + TEMP_W'(1);
          end
          COOL: begin
            if (troom == '0)
              sat <= 1'b1;
            else
              troom <= troom - TEMP_W'(1);
          end
          DRIFT: begin
            if (troom < tamb)
              troom <= troom + TEMP_W'(1);
            else if (troom > tamb)
              troom <= troom - TEMP_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule
